// File: rtl/idex_redirect_stage.sv
`default_nettype none
// ============================================================================
// Module   : idex_redirect_stage
// Brief    : ID/EX pipeline register with MEM/WB operand forwarding and a
//            one-cycle load-use interlock for the five-stage MIPS pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module idex_redirect_stage #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [3:0]    id_alu_op,
    input  logic          id_dmload,
    input  logic          id_dmstr,
    input  logic          id_dmsel,
    input  logic          id_regwrite,
    input  logic [4:0]    id_ra,
    input  logic [4:0]    id_rb,
    input  logic          id_use_a,
    input  logic          id_use_b,
    input  logic [4:0]    id_rw,
    input  logic [15:0]   id_imm,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] id_a,
    input  logic [DW-1:0] id_b,
    input  logic          flush,
    input  logic          mem_regwrite,
    input  logic [4:0]    mem_rw,
    input  logic [DW-1:0] mem_data,
    input  logic          wb_regwrite,
    input  logic [4:0]    wb_rw,
    input  logic [DW-1:0] wb_data,
    output logic          id_stall,
    output logic          ex_valid,
    output logic [3:0]    ex_alu_op,
    output logic          ex_dmload,
    output logic          ex_dmstr,
    output logic          ex_dmsel,
    output logic          ex_regwrite,
    output logic [4:0]    ex_rw,
    output logic [15:0]   ex_imm,
    output logic [DW-1:0] ex_pc,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [1:0]    fwd_sel_a,
    output logic [1:0]    fwd_sel_b,
    output logic [CW-1:0] stall_count,
    output logic [CW-1:0] flush_count
);

    localparam logic [1:0] C_SEL_REG = 2'd0;
    localparam logic [1:0] C_SEL_MEM = 2'd1;
    localparam logic [1:0] C_SEL_WB  = 2'd2;
    localparam logic [4:0] C_R0      = 5'd0;

    logic          r_valid;
    logic [3:0]    r_alu_op;
    logic          r_dmload;
    logic          r_dmstr;
    logic          r_dmsel;
    logic          r_regwrite;
    logic [4:0]    r_rw;
    logic [15:0]   r_imm;
    logic [DW-1:0] r_pc;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [4:0]    r_ra;
    logic [4:0]    r_rb;
    logic          r_use_a;
    logic          r_use_b;
    logic [CW-1:0] r_stall_cnt;
    logic [CW-1:0] r_flush_cnt;

    logic          w_hit_a;
    logic          w_hit_b;
    logic          w_load_use;
    logic          w_bubble;
    logic          w_stall;
    logic          w_kill;
    logic          w_wb_byp_a;
    logic          w_wb_byp_b;
    logic [DW-1:0] w_cap_a;
    logic [DW-1:0] w_cap_b;
    logic [1:0]    w_sel_a;
    logic [1:0]    w_sel_b;

    // Load-use hazard: a valid load in EX whose destination is read by the
    // instruction currently in decode.
    always_comb begin
        w_hit_a    = id_use_a && (id_ra == r_rw);
        w_hit_b    = id_use_b && (id_rb == r_rw);
        w_load_use = id_valid && r_valid && r_dmload && r_regwrite &&
                     (r_rw != C_R0) && (w_hit_a || w_hit_b);
        w_bubble   = flush || w_load_use;
        w_stall    = w_load_use && !flush;
        w_kill     = flush && id_valid;
    end

    // Register-file write and read in the same cycle: take the WB value.
    always_comb begin
        w_wb_byp_a = wb_regwrite && (wb_rw != C_R0) && (wb_rw == id_ra);
        w_wb_byp_b = wb_regwrite && (wb_rw != C_R0) && (wb_rw == id_rb);
        w_cap_a    = w_wb_byp_a ? wb_data : id_a;
        w_cap_b    = w_wb_byp_b ? wb_data : id_b;
    end

    // Control bits are gated by id_valid at capture so that they always read
    // zero while the slot is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_alu_op   <= 4'd0;
            r_dmload   <= 1'b0;
            r_dmstr    <= 1'b0;
            r_dmsel    <= 1'b0;
            r_regwrite <= 1'b0;
        end else if (w_bubble) begin
            r_valid    <= 1'b0;
            r_alu_op   <= 4'd0;
            r_dmload   <= 1'b0;
            r_dmstr    <= 1'b0;
            r_dmsel    <= 1'b0;
            r_regwrite <= 1'b0;
        end else begin
            r_valid    <= id_valid;
            r_alu_op   <= id_alu_op;
            r_dmload   <= id_dmload   && id_valid;
            r_dmstr    <= id_dmstr    && id_valid;
            r_dmsel    <= id_dmsel    && id_valid;
            r_regwrite <= id_regwrite && id_valid;
        end
    end

    // Data fields simply hold across a bubble; they are ignored while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rw    <= 5'd0;
            r_imm   <= 16'd0;
            r_pc    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_ra    <= 5'd0;
            r_rb    <= 5'd0;
            r_use_a <= 1'b0;
            r_use_b <= 1'b0;
        end else if (!w_bubble) begin
            r_rw    <= id_rw;
            r_imm   <= id_imm;
            r_pc    <= id_pc;
            r_a     <= w_cap_a;
            r_b     <= w_cap_b;
            r_ra    <= id_ra;
            r_rb    <= id_rb;
            r_use_a <= id_use_a;
            r_use_b <= id_use_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_kill && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    // EX-stage forwarding: MEM is younger than WB, so it wins.
    always_comb begin
        w_sel_a = C_SEL_REG;
        if (r_valid && r_use_a && (r_ra != C_R0)) begin
            if (mem_regwrite && (mem_rw == r_ra)) begin
                w_sel_a = C_SEL_MEM;
            end else if (wb_regwrite && (wb_rw == r_ra)) begin
                w_sel_a = C_SEL_WB;
            end
        end
    end

    always_comb begin
        w_sel_b = C_SEL_REG;
        if (r_valid && r_use_b && (r_rb != C_R0)) begin
            if (mem_regwrite && (mem_rw == r_rb)) begin
                w_sel_b = C_SEL_MEM;
            end else if (wb_regwrite && (wb_rw == r_rb)) begin
                w_sel_b = C_SEL_WB;
            end
        end
    end

    always_comb begin
        case (w_sel_a)
            C_SEL_MEM: ex_a = mem_data;
            C_SEL_WB:  ex_a = wb_data;
            default:   ex_a = r_a;
        endcase
        case (w_sel_b)
            C_SEL_MEM: ex_b = mem_data;
            C_SEL_WB:  ex_b = wb_data;
            default:   ex_b = r_b;
        endcase
    end

    assign id_stall    = w_stall;
    assign ex_valid    = r_valid;
    assign ex_alu_op   = r_alu_op;
    assign ex_dmload   = r_dmload;
    assign ex_dmstr    = r_dmstr;
    assign ex_dmsel    = r_dmsel;
    assign ex_regwrite = r_regwrite;
    assign ex_rw       = r_rw;
    assign ex_imm      = r_imm;
    assign ex_pc       = r_pc;
    assign fwd_sel_a   = w_sel_a;
    assign fwd_sel_b   = w_sel_b;
    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_idex_redirect_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_idex_redirect_stage
// Brief    : Directed and randomized bench for idex_redirect_stage against a
//            behavioural pipeline-slot model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idex_redirect_stage;

    localparam int DW = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_dmload, id_dmstr, id_dmsel, id_regwrite;
    logic [3:0]    id_alu_op;
    logic [4:0]    id_ra, id_rb, id_rw;
    logic          id_use_a, id_use_b;
    logic [15:0]   id_imm;
    logic [DW-1:0] id_pc, id_a, id_b;
    logic          flush;
    logic          mem_regwrite, wb_regwrite;
    logic [4:0]    mem_rw, wb_rw;
    logic [DW-1:0] mem_data, wb_data;
    logic          id_stall, ex_valid, ex_dmload, ex_dmstr, ex_dmsel, ex_regwrite;
    logic [3:0]    ex_alu_op;
    logic [4:0]    ex_rw;
    logic [15:0]   ex_imm;
    logic [DW-1:0] ex_pc, ex_a, ex_b;
    logic [1:0]    fwd_sel_a, fwd_sel_b;
    logic [CW-1:0] stall_count, flush_count;

    int n_checks = 0;
    int n_pass   = 0;

    idex_redirect_stage #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_alu_op(id_alu_op), .id_dmload(id_dmload),
        .id_dmstr(id_dmstr), .id_dmsel(id_dmsel), .id_regwrite(id_regwrite),
        .id_ra(id_ra), .id_rb(id_rb), .id_use_a(id_use_a), .id_use_b(id_use_b),
        .id_rw(id_rw), .id_imm(id_imm), .id_pc(id_pc), .id_a(id_a), .id_b(id_b),
        .flush(flush), .mem_regwrite(mem_regwrite), .mem_rw(mem_rw),
        .mem_data(mem_data), .wb_regwrite(wb_regwrite), .wb_rw(wb_rw),
        .wb_data(wb_data), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_alu_op(ex_alu_op), .ex_dmload(ex_dmload), .ex_dmstr(ex_dmstr),
        .ex_dmsel(ex_dmsel), .ex_regwrite(ex_regwrite), .ex_rw(ex_rw),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #10 clk = ~clk;

    // Model of the instruction occupying the EX slot.
    logic          m_valid, m_ld, m_st, m_sel, m_rwe, m_ua, m_ub;
    logic [3:0]    m_alu;
    logic [4:0]    m_rw, m_ra, m_rb;
    logic [15:0]   m_imm;
    logic [DW-1:0] m_pc, m_a, m_b;
    logic [CW-1:0] m_sc, m_fc;

    function automatic logic model_load_use();
        return id_valid && m_valid && m_ld && m_rwe && (m_rw != 5'd0) &&
               ((id_use_a && id_ra == m_rw) || (id_use_b && id_rb == m_rw));
    endfunction

    function automatic logic [DW-1:0] regfile_read(input logic [4:0] r, input logic [DW-1:0] v);
        if (wb_regwrite && r != 5'd0 && wb_rw == r) return wb_data;
        return v;
    endfunction

    function automatic logic [1:0] exp_sel(input logic rd, input logic [4:0] src);
        if (!m_valid || !rd || src == 5'd0) return 2'd0;
        if (mem_regwrite && mem_rw == src) return 2'd1;
        if (wb_regwrite && wb_rw == src) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [DW-1:0] exp_opnd(input logic [1:0] s, input logic [DW-1:0] v);
        if (s == 2'd1) return mem_data;
        if (s == 2'd2) return wb_data;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0; m_ld <= 0; m_st <= 0; m_sel <= 0; m_rwe <= 0;
            m_ua <= 0; m_ub <= 0; m_alu <= 0; m_rw <= 0; m_ra <= 0; m_rb <= 0;
            m_imm <= 0; m_pc <= 0; m_a <= 0; m_b <= 0; m_sc <= 0; m_fc <= 0;
        end else begin
            if (flush || model_load_use()) begin
                m_valid <= 0; m_ld <= 0; m_st <= 0; m_sel <= 0; m_rwe <= 0;
            end else begin
                m_valid <= id_valid; m_ld <= id_dmload; m_st <= id_dmstr;
                m_sel <= id_dmsel; m_rwe <= id_regwrite; m_alu <= id_alu_op;
                m_rw <= id_rw; m_ra <= id_ra; m_rb <= id_rb; m_ua <= id_use_a;
                m_ub <= id_use_b; m_imm <= id_imm; m_pc <= id_pc;
                m_a <= regfile_read(id_ra, id_a);
                m_b <= regfile_read(id_rb, id_b);
            end
            if (model_load_use() && !flush && m_sc != {CW{1'b1}}) m_sc <= m_sc + 1'b1;
            if (flush && id_valid && m_fc != {CW{1'b1}}) m_fc <= m_fc + 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Every cycle, compare the DUT against the model.
    always @(negedge clk) begin
        logic [1:0] sa, sb;
        #2;
        sa = exp_sel(m_ua, m_ra);
        sb = exp_sel(m_ub, m_rb);
        check("id_stall", id_stall, model_load_use() && !flush);
        check("ex_valid", ex_valid, m_valid);
        check("ex_dmload", ex_dmload, m_valid && m_ld);
        check("ex_dmstr", ex_dmstr, m_valid && m_st);
        check("ex_dmsel", ex_dmsel, m_valid && m_sel);
        check("ex_regwrite", ex_regwrite, m_valid && m_rwe);
        check("fwd_sel_a", fwd_sel_a, sa);
        check("fwd_sel_b", fwd_sel_b, sb);
        check("stall_count", stall_count, m_sc);
        check("flush_count", flush_count, m_fc);
        if (m_valid) begin
            check("ex_alu_op", ex_alu_op, m_alu);
            check("ex_rw", ex_rw, m_rw);
            check("ex_imm", ex_imm, m_imm);
            check("ex_pc", ex_pc, m_pc);
            check("ex_a", ex_a, exp_opnd(sa, m_a));
            check("ex_b", ex_b, exp_opnd(sb, m_b));
        end
    end

    task automatic clear_inputs();
        id_valid = 0; id_alu_op = 0; id_dmload = 0; id_dmstr = 0; id_dmsel = 0;
        id_regwrite = 0; id_ra = 0; id_rb = 0; id_use_a = 0; id_use_b = 0;
        id_rw = 0; id_imm = 0; id_pc = 0; id_a = 0; id_b = 0; flush = 0;
        mem_regwrite = 0; mem_rw = 0; mem_data = 0;
        wb_regwrite = 0; wb_rw = 0; wb_data = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_load(input logic [4:0] rw);
        clear_inputs();
        id_valid = 1; id_dmload = 1; id_regwrite = 1; id_rw = rw;
    endtask

    task automatic set_consumer(input logic [4:0] ra);
        clear_inputs();
        id_valid = 1; id_ra = ra; id_use_a = 1; id_rw = 5'd4; id_regwrite = 1;
        id_a = 32'h1111;
    endtask

    function automatic logic [4:0] rnd_reg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    task automatic randomize_inputs();
        id_valid = ($urandom_range(0, 3) != 0);
        id_alu_op = 4'($urandom);
        id_dmload = ($urandom_range(0, 2) == 0);
        id_dmstr = 1'($urandom); id_dmsel = 1'($urandom);
        id_regwrite = ($urandom_range(0, 3) != 0);
        id_ra = rnd_reg(); id_rb = rnd_reg(); id_rw = rnd_reg();
        id_use_a = 1'($urandom); id_use_b = 1'($urandom);
        id_imm = 16'($urandom); id_pc = $urandom; id_a = $urandom; id_b = $urandom;
        flush = ($urandom_range(0, 7) == 0);
        mem_regwrite = 1'($urandom); mem_rw = rnd_reg(); mem_data = $urandom;
        wb_regwrite = 1'($urandom); wb_rw = rnd_reg(); wb_data = $urandom;
    endtask

    initial begin
        rst_n = 1;
        clear_inputs();
        #1 rst_n = 0;
        // Reset with random inputs: everything reads zero.
        repeat (2) @(negedge clk);
        randomize_inputs();
        #3;
        check("rst ex_valid", ex_valid, 0);
        check("rst id_stall", id_stall, 0);
        check("rst ex_a", ex_a, 0);
        check("rst ex_pc", ex_pc, 0);
        check("rst fwd_sel_a", fwd_sel_a, 0);
        check("rst stall_count", stall_count, 0);

        @(negedge clk);
        rst_n = 1;
        clear_inputs();
        id_valid = 1; id_rw = 5'd5; id_alu_op = 4'h3;
        next_cycle();
        clear_inputs();
        #3;
        check("first ex_valid", ex_valid, 1);
        check("first ex_rw", ex_rw, 5);
        check("first ex_alu_op", ex_alu_op, 3);

        // MEM has priority over WB.
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_ra = 5'd8; id_use_a = 1; id_a = 32'h42;
        next_cycle();
        clear_inputs();
        mem_regwrite = 1; mem_rw = 5'd8; mem_data = 32'h1234;
        wb_regwrite = 1; wb_rw = 5'd8; wb_data = 32'h9999;
        #3;
        check("memfwd sel_a", fwd_sel_a, 1);
        check("memfwd ex_a", ex_a, 32'h1234);
        mem_rw = 5'd9;
        #1;
        check("wbfwd sel_a", fwd_sel_a, 2);
        check("wbfwd ex_a", ex_a, 32'h9999);

        // Load-use: one stall cycle, a bubble, then WB forwarding.
        @(negedge clk);
        set_load(5'd3);
        next_cycle();
        set_consumer(5'd3);
        #3;
        check("lu id_stall", id_stall, 1);
        next_cycle();
        #3;
        check("lu stall released", id_stall, 0);
        check("lu bubble", ex_valid, 0);
        check("lu stall_count", stall_count, 1);
        next_cycle();
        clear_inputs();
        wb_regwrite = 1; wb_rw = 5'd3; wb_data = 32'hABCD;
        #3;
        check("lu consumer valid", ex_valid, 1);
        check("lu consumer ex_a", ex_a, 32'hABCD);

        // Register 0 neither stalls nor forwards.
        @(negedge clk);
        set_load(5'd0);
        id_use_a = 1;
        next_cycle();
        clear_inputs();
        id_valid = 1; id_use_a = 1;
        #3;
        check("r0 id_stall", id_stall, 0);
        mem_regwrite = 1; wb_regwrite = 1;
        #1;
        check("r0 fwd_sel_a", fwd_sel_a, 0);

        // Flush beats stall.
        @(negedge clk);
        set_load(5'd3);
        next_cycle();
        set_consumer(5'd3);
        flush = 1;
        #3;
        check("flush id_stall", id_stall, 0);
        next_cycle();
        clear_inputs();
        #3;
        check("flush bubble", ex_valid, 0);
        check("flush_count", flush_count, 1);
        check("flush stall_count", stall_count, 1);

        // Five more stall events saturate the 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_load(5'd3);
            next_cycle();
            set_consumer(5'd3);
            next_cycle();
        end
        clear_inputs();
        #3;
        check("stall saturate", stall_count, 3);

        // Capture-time WB bypass on B.
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_rb = 5'd7; id_use_b = 1; id_b = 32'h11;
        wb_regwrite = 1; wb_rw = 5'd7; wb_data = 32'h55;
        next_cycle();
        clear_inputs();
        #3;
        check("byp ex_b", ex_b, 32'h55);
        check("byp fwd_sel_b", fwd_sel_b, 0);

        // Randomized traffic with a mid-run asynchronous reset.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c == 1500) rst_n = 0;
            if (c == 1503) rst_n = 1;
            randomize_inputs();
        end

        @(negedge clk);
        #5;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
